// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the oversampled SPI slave.
// Quad-line operation is compiled in with SPI_SLAVE_QUAD_EN.
package spi_slave_pkg;

  localparam logic [1:0] MODE_STD     = 2'd0;
  localparam logic [1:0] MODE_QUAD_TX = 2'd1;
  localparam logic [1:0] MODE_QUAD_RX = 2'd2;

  typedef enum logic [1:0] {
    STD     = MODE_STD,
    QUAD_TX = MODE_QUAD_TX,
    QUAD_RX = MODE_QUAD_RX
  } spi_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_e;

  // The unused encoding (3) falls back to standard single-line operation.
  function automatic spi_mode_e decode_mode(input logic [1:0] mode);
    case (mode)
      MODE_QUAD_TX: decode_mode = QUAD_TX;
      MODE_QUAD_RX: decode_mode = QUAD_RX;
      default:      decode_mode = STD;
    endcase
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-stage synchronizer for one SPI pin, resetting to a chosen idle level.
module spi_slave_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_os.sv
// Oversampled SPI mode-0 slave: SCK/CSN/SDI sampled in clk, bytes exchanged via valid/ready.
// Optional quad-line modes are enabled by defining SPI_SLAVE_QUAD_EN.
module spi_slave_os
  import spi_slave_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck_i,
  input  logic       spi_csn_i,
  input  logic [3:0] spi_sdi_i,
  output logic [3:0] spi_sdo_o,
  output logic [3:0] spi_sdo_oe_o,
`ifdef SPI_SLAVE_QUAD_EN
  input  logic [1:0] spi_mode_i,
`endif
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       overrun_o,
  output logic       underrun_o,
  input  logic       err_clr_i,
  output logic       busy_o
);

  logic       sck_p0, csn_p0;
  logic [3:0] sdi_p0;
  logic       sck_p1, csn_p1;

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst_n(rst_n), .d(spi_sck_i), .q(sck_p0));
  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
    .clk(clk), .rst_n(rst_n), .d(spi_csn_i), .q(csn_p0));

`ifdef SPI_SLAVE_QUAD_EN
  for (genvar i = 0; i < 4; i++) begin : g_sdi_sync
    spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi_sync (
      .clk(clk), .rst_n(rst_n), .d(spi_sdi_i[i]), .q(sdi_p0[i]));
  end
`else
  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi_sync (
    .clk(clk), .rst_n(rst_n), .d(spi_sdi_i[0]), .q(sdi_p0[0]));
  assign sdi_p0[3:1] = 3'b000;
  logic unused_sdi;
  assign unused_sdi = ^spi_sdi_i[3:1];
`endif

  // ---- stage p1: previous synced levels for edge detection ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_p1 <= 1'b0;
      csn_p1 <= 1'b1;
    end else begin
      sck_p1 <= sck_p0;
      csn_p1 <= csn_p0;
    end
  end

  logic sck_rise, sck_fall, csn_fall, csn_rise;
  assign sck_rise = sck_p0 & ~sck_p1;
  assign sck_fall = ~sck_p0 & sck_p1;
  assign csn_fall = ~csn_p0 & csn_p1;
  assign csn_rise = csn_p0 & ~csn_p1;

  state_e     state;
  spi_mode_e  mode_q;
  logic [7:0] tx_sr, rx_sr, tx_buf;
  logic [2:0] bitcnt;
  logic       reload_pend, tx_full;

  logic       byte_last, load_evt, pop, under_set, byte_done, deliver, over_set, accept;
  logic [7:0] rx_next, load_byte;

  assign byte_last = (mode_q == STD) ? (bitcnt == 3'd7) : (bitcnt == 3'd1);
  assign rx_next   = (mode_q == QUAD_RX) ? {rx_sr[3:0], sdi_p0} : {rx_sr[6:0], sdi_p0[0]};
  assign load_evt  = ((state == LOAD) && !csn_rise) ||
                     ((state == SHIFT) && !csn_rise && sck_fall && reload_pend);
  assign pop       = load_evt & tx_full;
  assign under_set = load_evt & ~tx_full;
  assign load_byte = tx_full ? tx_buf : FILL_BYTE;
  assign byte_done = (state == SHIFT) && !csn_rise && sck_rise && byte_last;
  // In QUAD_TX the data lines are all driven by us, so nothing meaningful is received.
  assign deliver   = byte_done && (mode_q != QUAD_TX);
  assign over_set  = deliver & rx_valid_o & ~rx_ready_i;
  assign accept    = tx_valid_i & ~tx_full;

  // ---- stage p2: frame FSM and shift registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_q      <= STD;
      tx_sr       <= 8'h00;
      rx_sr       <= 8'h00;
      bitcnt      <= 3'd0;
      reload_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (csn_fall) state <= LOAD;
        end
        LOAD: begin
          if (csn_rise) begin
            state <= IDLE;
          end else begin
            tx_sr <= load_byte;
`ifdef SPI_SLAVE_QUAD_EN
            mode_q <= decode_mode(spi_mode_i);
`else
            mode_q <= STD;
`endif
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (csn_rise) begin
            state       <= IDLE;
            mode_q      <= STD;
            tx_sr       <= 8'h00;
            rx_sr       <= 8'h00;
            bitcnt      <= 3'd0;
            reload_pend <= 1'b0;
          end else begin
            if (sck_rise) begin
              rx_sr  <= rx_next;
              bitcnt <= byte_last ? 3'd0 : bitcnt + 3'd1;
              if (byte_last) reload_pend <= 1'b1;
            end
            if (sck_fall) begin
              if (reload_pend) begin
                tx_sr       <= load_byte;
                reload_pend <= 1'b0;
              end else if (mode_q == QUAD_TX) begin
                tx_sr <= {tx_sr[3:0], 4'h0};
              end else begin
                tx_sr <= {tx_sr[6:0], 1'b0};
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p2: fabric-side handshakes and sticky flags ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_o  <= 8'h00;
      rx_valid_o <= 1'b0;
      overrun_o  <= 1'b0;
      underrun_o <= 1'b0;
      tx_buf     <= 8'h00;
      tx_full    <= 1'b0;
    end else begin
      if (deliver && !(rx_valid_o && !rx_ready_i)) begin
        rx_data_o  <= rx_next;
        rx_valid_o <= 1'b1;
      end else if (rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      overrun_o  <= over_set  | (overrun_o  & ~err_clr_i);
      underrun_o <= under_set | (underrun_o & ~err_clr_i);
      if (accept) begin
        tx_buf  <= tx_data_i;
        tx_full <= 1'b1;
      end else if (pop) begin
        tx_full <= 1'b0;
      end
    end
  end

  assign tx_ready_o = ~tx_full;
  assign busy_o     = ~csn_p0;

  always_comb begin
    spi_sdo_o    = {3'b000, tx_sr[7]};
    spi_sdo_oe_o = {3'b000, busy_o};
`ifdef SPI_SLAVE_QUAD_EN
    if (mode_q == QUAD_TX) begin
      spi_sdo_o    = tx_sr[7:4];
      spi_sdo_oe_o = busy_o ? 4'hF : 4'h0;
    end else if (mode_q == QUAD_RX) begin
      spi_sdo_o    = 4'h0;
      spi_sdo_oe_o = 4'h0;
    end
`endif
  end

endmodule

// File: tb/tb_spi_slave_os.sv
// Directed bench for spi_slave_os; quad-mode steps are built when SPI_SLAVE_QUAD_EN is defined.
module tb_spi_slave_os;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n, sck, csn, rx_ready, tx_valid, err_clr;
  logic [3:0] sdi, sdo, oe;
  logic [1:0] mode;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_ready, overrun, underrun, busy;
  logic [7:0] miso, miso2;
  logic [3:0] oe_seen;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_slave_os #(.SYNC_STAGES(2), .FILL_BYTE(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sck_i(sck), .spi_csn_i(csn), .spi_sdi_i(sdi),
    .spi_sdo_o(sdo), .spi_sdo_oe_o(oe),
`ifdef SPI_SLAVE_QUAD_EN
    .spi_mode_i(mode),
`endif
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .overrun_o(overrun), .underrun_o(underrun), .err_clr_i(err_clr),
    .busy_o(busy)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tx_write(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  // Mode-0 master: MISO sampled just before each rising SCK edge.
  task automatic spi_xfer(input logic [7:0] mosi, input int nbits, input int wr_bit,
                          input logic [7:0] wr_data, output logic [7:0] rd);
    rd = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sdi[0] = mosi[7-i];
      if (i == wr_bit) tx_write(wr_data);
      else tick(1);
      tick(HALF - 1);
      rd  = {rd[6:0], sdo[0]};
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
      tick(HALF);
    end
  endtask

  task automatic spi_qxfer(input logic [7:0] mosi, output logic [7:0] rd, output logic [3:0] oe_s);
    rd   = 8'h00;
    oe_s = 4'h0;
    for (int i = 0; i < 2; i++) begin
      sdi = (i == 0) ? mosi[7:4] : mosi[3:0];
      tick(HALF);
      rd   = {rd[3:0], sdo};
      oe_s = oe;
      sck  = 1'b1;
      tick(HALF);
      sck  = 1'b0;
      tick(HALF);
    end
  endtask

  initial begin
    rst_n = 1'b0; csn = 1'b1; sck = 1'b0; sdi = 4'h0; mode = 2'd0;
    rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; err_clr = 1'b0;
    tick(3);
    check("rst_rx_valid", 8'(rx_valid), 8'd0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_tx_ready", 8'(tx_ready), 8'd1);
    check("rst_overrun", 8'(overrun), 8'd0);
    check("rst_underrun", 8'(underrun), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_sdo", 8'(sdo), 8'h0);
    check("rst_oe", 8'(oe), 8'h0);
    rst_n = 1'b1;
    tick(3);

    // Basic full-duplex byte: A5 out, 3C in.
    tx_write(8'hA5);
    check("buf_full_ready", 8'(tx_ready), 8'd0);
    csn = 1'b0;
    tick(HALF);
    check("busy_low_csn", 8'(busy), 8'd1);
    check("oe_std", 8'(oe), 8'h1);
    check("pop_ready", 8'(tx_ready), 8'd1);
    check("first_sdo_msb", 8'(sdo), 8'h1);
    spi_xfer(8'h3C, 8, -1, 8'h00, miso);
    check("miso_a5", miso, 8'hA5);
    check("rx_3c", rx_data, 8'h3C);
    check("rx_valid_3c", 8'(rx_valid), 8'd1);
    check("underrun_reload", 8'(underrun), 8'd1);
    csn = 1'b1;
    tick(HALF);
    check("busy_idle", 8'(busy), 8'd0);
    check("oe_idle", 8'(oe), 8'h0);
    check("sdo_idle", 8'(sdo), 8'h0);
    check("rx_valid_held", 8'(rx_valid), 8'd1);
    pulse_ready();
    check("rx_valid_consumed", 8'(rx_valid), 8'd0);
    pulse_clr();
    check("underrun_clr", 8'(underrun), 8'd0);

    // Overrun: two bytes with nobody consuming.
    csn = 1'b0;
    tick(HALF);
    spi_xfer(8'h11, 8, -1, 8'h00, miso);
    check("miso_fill", miso, 8'hFF);
    check("underrun_empty", 8'(underrun), 8'd1);
    check("rx_11", rx_data, 8'h11);
    check("overrun_none_yet", 8'(overrun), 8'd0);
    spi_xfer(8'h22, 8, -1, 8'h00, miso);
    check("overrun_set", 8'(overrun), 8'd1);
    check("rx_keeps_11", rx_data, 8'h11);
    csn = 1'b1;
    tick(HALF);
    pulse_clr();
    check("overrun_clr", 8'(overrun), 8'd0);
    check("underrun_clr2", 8'(underrun), 8'd0);
    pulse_ready();

    // Underrun then mid-byte write used for the next byte.
    rx_ready = 1'b1;
    csn = 1'b0;
    tick(HALF);
    spi_xfer(8'h00, 8, 3, 8'h5A, miso);
    check("miso_fill2", miso, 8'hFF);
    check("underrun_set2", 8'(underrun), 8'd1);
    check("midbyte_popped", 8'(tx_ready), 8'd1);
    spi_xfer(8'h77, 8, -1, 8'h00, miso2);
    check("miso_5a", miso2, 8'h5A);
    check("rx_77", rx_data, 8'h77);
    check("no_overrun_ready", 8'(overrun), 8'd0);
    check("rx_valid_autoconsumed", 8'(rx_valid), 8'd0);
    csn = 1'b1;
    tick(HALF);
    rx_ready = 1'b0;
    pulse_clr();

    // Abort after 5 bits, then a clean frame.
    tx_write(8'h3C);
    csn = 1'b0;
    tick(HALF);
    spi_xfer(8'hF0, 5, -1, 8'h00, miso);
    csn = 1'b1;
    tick(HALF);
    check("abort_no_valid", 8'(rx_valid), 8'd0);
    check("abort_tx_lost", 8'(tx_ready), 8'd1);
    check("abort_no_overrun", 8'(overrun), 8'd0);
    check("abort_no_underrun", 8'(underrun), 8'd0);
    csn = 1'b0;
    tick(HALF);
    spi_xfer(8'h81, 8, -1, 8'h00, miso);
    csn = 1'b1;
    tick(HALF);
    check("rx_81", rx_data, 8'h81);
    check("rx_valid_81", 8'(rx_valid), 8'd1);
    check("miso_after_abort", miso, 8'hFF);

    // Reset mid-byte with flags and buffer populated.
    csn = 1'b0;
    tick(HALF);
    tx_write(8'hC3);
    spi_xfer(8'hAA, 3, -1, 8'h00, miso);
    check("pre_rst_underrun", 8'(underrun), 8'd1);
    rst_n = 1'b0;
    tick(1);
    csn = 1'b1;
    check("midrst_rx_valid", 8'(rx_valid), 8'd0);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_tx_ready", 8'(tx_ready), 8'd1);
    check("midrst_underrun", 8'(underrun), 8'd0);
    check("midrst_busy", 8'(busy), 8'd0);
    check("midrst_oe", 8'(oe), 8'h0);
    tick(2);
    rst_n = 1'b1;
    tick(HALF);
    csn = 1'b0;
    tick(HALF);
    spi_xfer(8'hE7, 8, -1, 8'h00, miso);
    csn = 1'b1;
    tick(HALF);
    check("post_rst_rx", rx_data, 8'hE7);
    check("post_rst_miso", miso, 8'hFF);
    pulse_ready();
    pulse_clr();

`ifdef SPI_SLAVE_QUAD_EN
    mode = 2'd2;
    csn = 1'b0;
    tick(HALF);
    spi_qxfer(8'h96, miso, oe_seen);
    csn = 1'b1;
    tick(HALF);
    check("quad_rx_96", rx_data, 8'h96);
    check("quad_rx_oe", 8'(oe_seen), 8'h0);
    pulse_ready();
    mode = 2'd1;
    tx_write(8'hC3);
    csn = 1'b0;
    tick(HALF);
    spi_qxfer(8'h00, miso, oe_seen);
    csn = 1'b1;
    tick(HALF);
    check("quad_tx_c3", miso, 8'hC3);
    check("quad_tx_oe", 8'(oe_seen), 8'hF);
    mode = 2'd0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
